// File: rtl/dmem_line_responder_if.sv
// Refill/eviction bus between the dCache (master) and the data-memory responder (slave).
interface dmem_line_responder_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned LINE_WIDTH = 128
);
    logic                  req_dCache_mem;
    logic [ADDR_WIDTH-1:0] req_dCache_mem_addr;
    logic                  evict_valid;
    logic [ADDR_WIDTH-1:0] evict_addr;
    logic [LINE_WIDTH-1:0] evict_data;
    logic [LINE_WIDTH-1:0] data_to_fill;
    logic                  mem_data_rdy;
    logic                  evict_ack;
    logic                  busy;

    modport master (
        output req_dCache_mem, req_dCache_mem_addr, evict_valid, evict_addr, evict_data,
        input  data_to_fill, mem_data_rdy, evict_ack, busy
    );

    modport slave (
        input  req_dCache_mem, req_dCache_mem_addr, evict_valid, evict_addr, evict_data,
        output data_to_fill, mem_data_rdy, evict_ack, busy
    );
endinterface

// File: rtl/dmem_line_responder.sv
// Data-memory line responder behind the dCache: absorbs an optional dirty victim,
// then returns the requested line after a fixed access latency.
module dmem_line_responder #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned NLINES     = 256,
    parameter int unsigned LATENCY    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    dmem_line_responder_if.slave   bus
);
    localparam int unsigned OFS_W = 4;
    localparam int unsigned IDX_W = (NLINES > 1) ? $clog2(NLINES) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, WB, FILL, RESP, TURN} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      fill_idx;
    logic [IDX_W-1:0]      vic_idx;
    logic [LINE_WIDTH-1:0] vic_line;
    logic [LINE_WIDTH-1:0] mem [NLINES];

    logic cnt_last_c;
    logic wb_commit_c;
    logic unused_addr_bits_c;

    assign cnt_last_c  = (cnt == CNT_W'(LATENCY - 1));
    assign wb_commit_c = (state == WB) && cnt_last_c;

    // Offset and above-index address bits never select storage.
    assign unused_addr_bits_c = ^{bus.req_dCache_mem_addr[OFS_W-1:0],
                                  bus.req_dCache_mem_addr[ADDR_WIDTH-1:OFS_W+IDX_W],
                                  bus.evict_addr[OFS_W-1:0],
                                  bus.evict_addr[ADDR_WIDTH-1:OFS_W+IDX_W]};

    // Backing store is deliberately not reset; a reset during WB never reaches here.
    always_ff @(posedge clk) begin
        if (wb_commit_c) begin
            mem[vic_idx] <= vic_line;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            fill_idx         <= '0;
            vic_idx          <= '0;
            vic_line         <= '0;
            bus.data_to_fill <= '0;
            bus.mem_data_rdy <= 1'b0;
            bus.evict_ack    <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.mem_data_rdy <= 1'b0;
            bus.evict_ack    <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.req_dCache_mem) begin
                        fill_idx <= bus.req_dCache_mem_addr[OFS_W +: IDX_W];
                        bus.busy <= 1'b1;
                        if (bus.evict_valid) begin
                            vic_idx  <= bus.evict_addr[OFS_W +: IDX_W];
                            vic_line <= bus.evict_data;
                            state    <= WB;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                WB: begin
                    if (cnt_last_c) begin
                        bus.evict_ack <= 1'b1;
                        cnt           <= '0;
                        state         <= FILL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FILL: begin
                    if (cnt_last_c) begin
                        bus.data_to_fill <= mem[fill_idx];
                        bus.mem_data_rdy <= 1'b1;
                        cnt              <= '0;
                        state            <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: state <= TURN;
                // Dead cycle lets the dCache drop its level request.
                TURN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: refill latency, write-back ordering,
// back-to-back handshake, reset during write-back and address stability.
module tb_dmem_line_responder;
    localparam logic [127:0] LINE_A5   = {16{8'hA5}};
    localparam logic [127:0] LINE_0011 = 128'h0011_0101_0101_0101_0101_0101_0101_0101;
    localparam logic [127:0] LINE_DEAD = {4{32'hDEADBEEF}};
    localparam logic [127:0] LINE_FF   = {128{1'b1}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rdy_k;
    int   ack_k;
    int   rdy_cnt;
    logic [127:0] got;

    dmem_line_responder_if #(.ADDR_WIDTH(20), .LINE_WIDTH(128)) bus ();

    dmem_line_responder #(
        .ADDR_WIDTH(20), .LINE_WIDTH(128), .NLINES(256), .LATENCY(5)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; k counts negedges after the acceptance edge (k=0 is the first).
    task automatic do_req(input logic [19:0] a, input logic [19:0] a_late, input logic ev,
                          input logic [19:0] ea, input logic [127:0] ed, input bit hold,
                          output int rk, output int ak, output int rc, output logic [127:0] d);
        rk = -1; ak = -1; rc = 0; d = '0;
        bus.req_dCache_mem      = 1'b1;
        bus.req_dCache_mem_addr = a;
        bus.evict_valid         = ev;
        bus.evict_addr          = ea;
        bus.evict_data          = ed;
        @(posedge clk);
        for (int k = 0; k < 40 && rk < 0; k++) begin
            @(negedge clk);
            bus.evict_valid = 1'b0;
            bus.evict_addr  = '0;
            bus.evict_data  = '0;
            if (k == 2) bus.req_dCache_mem_addr = a_late;
            if (bus.evict_ack) ak = k;
            if (bus.mem_data_rdy) begin
                rk = k;
                rc++;
                d  = bus.data_to_fill;
                if (!hold) bus.req_dCache_mem = 1'b0;
            end
        end
    endtask

    // From the mem_data_rdy negedge: pulse is single, TURN still busy, then idle with data held.
    task automatic finish_txn(input string tag, input logic [127:0] exp);
        @(negedge clk);
        check({tag, "_rdy_single"}, 128'(bus.mem_data_rdy), 128'd0);
        check({tag, "_turn_busy"}, 128'(bus.busy), 128'd1);
        @(negedge clk);
        check({tag, "_idle_busy"}, 128'(bus.busy), 128'd0);
        check({tag, "_data_hold"}, bus.data_to_fill, exp);
    endtask

    initial begin
        bus.req_dCache_mem      = 1'b0;
        bus.req_dCache_mem_addr = '0;
        bus.evict_valid         = 1'b0;
        bus.evict_addr          = '0;
        bus.evict_data          = '0;
        repeat (2) @(negedge clk);
        check("rst_rdy", 128'(bus.mem_data_rdy), 128'd0);
        check("rst_ack", 128'(bus.evict_ack), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_data", bus.data_to_fill, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray evict_valid without a request is ignored.
        bus.evict_valid = 1'b1;
        bus.evict_addr  = 20'h050;
        bus.evict_data  = LINE_FF;
        repeat (3) @(negedge clk);
        check("stray_ev_busy", 128'(bus.busy), 128'd0);
        check("stray_ev_ack", 128'(bus.evict_ack), 128'd0);
        bus.evict_valid = 1'b0;

        // Preload line 0x05 with A5 through a write-back.
        do_req(20'h100, 20'h100, 1'b1, 20'h050, LINE_A5, 1'b0, rdy_k, ack_k, rdy_cnt, got);
        check("pre_ack_k", 128'(ack_k), 128'd5);
        check("pre_rdy_k", 128'(rdy_k), 128'd10);
        repeat (2) @(negedge clk);

        // Test 1: plain refill.
        do_req(20'h050, 20'h050, 1'b0, '0, '0, 1'b0, rdy_k, ack_k, rdy_cnt, got);
        check("t1_rdy_k", 128'(rdy_k), 128'd5);
        check("t1_no_ack", 128'(ack_k), 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        check("t1_data", got, LINE_A5);
        finish_txn("t1", LINE_A5);

        // Test 2: refill with a victim, then read the victim back.
        do_req(20'h0F0, 20'h0F0, 1'b1, 20'h020, LINE_0011, 1'b0, rdy_k, ack_k, rdy_cnt, got);
        check("t2_ack_k", 128'(ack_k), 128'd5);
        check("t2_rdy_k", 128'(rdy_k), 128'd10);
        finish_txn("t2", got);
        do_req(20'h020, 20'h020, 1'b0, '0, '0, 1'b0, rdy_k, ack_k, rdy_cnt, got);
        check("t2_rb_rdy_k", 128'(rdy_k), 128'd5);
        check("t2_rb_data", got, LINE_0011);
        finish_txn("t2rb", LINE_0011);

        // Test 3: victim and refill share an index; write must land first.
        do_req(20'h030, 20'h030, 1'b1, 20'h030, LINE_DEAD, 1'b0, rdy_k, ack_k, rdy_cnt, got);
        check("t3_ack_k", 128'(ack_k), 128'd5);
        check("t3_data", got, LINE_DEAD);
        finish_txn("t3", LINE_DEAD);

        // Test 4: request held across two transactions.
        do_req(20'h050, 20'h050, 1'b0, '0, '0, 1'b1, rdy_k, ack_k, rdy_cnt, got);
        check("t4a_rdy_k", 128'(rdy_k), 128'd5);
        check("t4a_data", got, LINE_A5);
        bus.req_dCache_mem_addr = 20'h020;
        @(negedge clk);
        check("t4_turn_rdy", 128'(bus.mem_data_rdy), 128'd0);
        check("t4_turn_busy", 128'(bus.busy), 128'd1);
        @(negedge clk);
        check("t4_idle_busy", 128'(bus.busy), 128'd0);
        check("t4_idle_rdy", 128'(bus.mem_data_rdy), 128'd0);
        do_req(20'h020, 20'h020, 1'b0, '0, '0, 1'b0, rdy_k, ack_k, rdy_cnt, got);
        check("t4b_rdy_k", 128'(rdy_k), 128'd5);
        check("t4b_rdy_cnt", 128'(rdy_cnt), 128'd1);
        check("t4b_data", got, LINE_0011);
        finish_txn("t4b", LINE_0011);

        // Test 5: reset while the write-back counter sits at 2.
        bus.req_dCache_mem      = 1'b1;
        bus.req_dCache_mem_addr = 20'h0F0;
        bus.evict_valid         = 1'b1;
        bus.evict_addr          = 20'h020;
        bus.evict_data          = LINE_FF;
        @(posedge clk);
        @(negedge clk);
        bus.req_dCache_mem = 1'b0;
        bus.evict_valid    = 1'b0;
        check("t5_wb_busy", 128'(bus.busy), 128'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("t5_pre_ack", 128'(bus.evict_ack), 128'd0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 128'(bus.busy), 128'd0);
        check("t5_rst_rdy", 128'(bus.mem_data_rdy), 128'd0);
        check("t5_rst_ack", 128'(bus.evict_ack), 128'd0);
        check("t5_rst_data", bus.data_to_fill, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("t5_post_ack", 128'(bus.evict_ack), 128'd0);
        end
        do_req(20'h020, 20'h020, 1'b0, '0, '0, 1'b0, rdy_k, ack_k, rdy_cnt, got);
        check("t5_rdy_k", 128'(rdy_k), 128'd5);
        check("t5_victim_kept", got, LINE_0011);
        finish_txn("t5", LINE_0011);

        // Test 6: address changes during FILL are ignored.
        do_req(20'h050, 20'h060, 1'b0, '0, '0, 1'b0, rdy_k, ack_k, rdy_cnt, got);
        check("t6_rdy_k", 128'(rdy_k), 128'd5);
        check("t6_data", got, LINE_A5);
        finish_txn("t6", LINE_A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
